// File: rtl/lsu_port_b.sv
// lsu_port_b: load/store unit between the core memory stage and port B of the
// dual-port data RAM. One byte/half/word access at a time with alignment check,
// sign/zero extension of load data, and read-modify-write for partial stores
// outside lane 0 (the RAM only takes write masks 0001, 0011 and 1111).
//
// Ports:
//   clk, rst_i                  clock, async active-high reset
//   req_valid_i / req_ready_o   request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i  request
//   rsp_valid_o, rsp_rdata_o, rsp_err_o                           response pulse
//   mem_addr_o, mem_en_o, mem_we_o, mem_wdata_o, mem_rdata_i      RAM port B
module lsu_port_b #(
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rmw_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    // Request decode (IDLE only): error, aligned address, lane-0 store.
    logic        req_err;
    logic [31:0] req_addr_al;
    logic        req_lane0;

    always_comb begin
        req_err     = (req_size_i == 2'b11);
        req_addr_al = req_addr_i;
        if (MISALIGN_ERR) begin
            if (req_size_i == SZ_H && req_addr_i[0])          req_err = 1'b1;
            if (req_size_i == SZ_W && req_addr_i[1:0] != 2'b00) req_err = 1'b1;
        end else begin
            // Misaligned requests are silently snapped to natural alignment.
            if (req_size_i == SZ_H) req_addr_al[0]   = 1'b0;
            if (req_size_i == SZ_W) req_addr_al[1:0] = 2'b00;
        end
        req_lane0 = (req_size_i == SZ_W)
                 || (req_size_i == SZ_B && req_addr_al[1:0] == 2'b00)
                 || (req_size_i == SZ_H && !req_addr_al[1]);
    end

    // Lane extraction and extension of load data.
    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Merge of new byte/half into the word captured in RMW_RD. Only non-lane-0
    // partial stores get here, so a half always lands in the upper lane.
    logic [31:0] merged;
    always_comb begin
        merged = rmw_q;
        if (size_q == SZ_B) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    // Port-B decode. State resets asynchronously, so these drop immediately
    // on rst_i, aborting any in-flight write.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_wdata_o = 32'd0;
        mem_addr_o  = 32'd0;
        case (state)
            LOAD, RMW_RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = {addr_q[31:2], 2'b00};
            end
            STORE: begin
                mem_en_o    = 1'b1;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_wdata_o = wdata_q;
                case (size_q)
                    SZ_W:    mem_we_o = 4'b1111;
                    SZ_H:    mem_we_o = 4'b0011;
                    default: mem_we_o = 4'b0001;
                endcase
            end
            RMW_WR: begin
                mem_en_o    = 1'b1;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_we_o    = 4'b1111;
                mem_wdata_o = merged;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rmw_q       <= 32'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Ready rises one cycle after reset release.
                    ready_q <= 1'b1;
                    if (req_valid_i && ready_q) begin
                        ready_q <= 1'b0;
                        we_q    <= req_we_i;
                        size_q  <= req_size_i;
                        uns_q   <= req_unsigned_i;
                        addr_q  <= req_addr_al;
                        wdata_q <= req_wdata_i;
                        if (req_err) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (!req_we_i) begin
                            state <= LOAD;
                        end else if (req_lane0) begin
                            state <= STORE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata_q <= load_ext(mem_rdata_i, size_q, uns_q, addr_q[1:0]);
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                STORE, RMW_WR: begin
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RMW_RD: begin
                    rmw_q <= mem_rdata_i;
                    state <= RMW_WR;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_port_b.sv
module tb_lsu_port_b;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    lsu_port_b #(.MISALIGN_ERR(1'b1)) dut (
        .clk(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, byte-masked write on rising edge,
    // plus a preload port so only this block writes the array.
    logic [31:0] ram [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_dat = 32'd0;

    assign mem_rdata_i = ram[mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_idx] <= pre_dat;
        end else if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          en;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One request: push expectation, drive, collect port-B activity until the
    // response, then compare against the popped expectation.
    task automatic run(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                       input int e_en, input logic [3:0] e_we, input logic [31:0] e_wdata);
        exp_t e, g;
        int lat, en;
        bit got;
        logic [3:0]  lwe;
        logic [31:0] lwd, ladr, rd;
        logic        er;
        e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.en = e_en;
        e.we = e_we; e.wdata = e_wdata;
        e.addr = (e_en > 0) ? {addr[31:2], 2'b00} : 32'd0;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, ".ready"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata;
        @(posedge clk);
        #1;
        // Scramble request after acceptance; it must have no effect.
        req_valid_i = 1'b0; req_we_i = ~we; req_unsigned_i = ~uns;
        req_addr_i = ~addr; req_wdata_i = ~wdata;
        lat = 0; en = 0; got = 0; lwe = 4'd0; lwd = 32'd0; ladr = 32'd0; rd = 32'd0; er = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_en_o) begin
                en++; lwe = mem_we_o; lwd = mem_wdata_o; ladr = mem_addr_o;
            end
            if (rsp_valid_o) begin
                got = 1; rd = rsp_rdata_o; er = rsp_err_o;
            end
        end
        g = sb.pop_front();
        chk({tag, ".rsp_seen"}, {31'd0, got}, 32'd1);
        chk({tag, ".rdata"}, rd, g.rdata);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, g.err});
        chk({tag, ".latency"}, lat, g.lat);
        chk({tag, ".en_cycles"}, en, g.en);
        chk({tag, ".we"}, {28'd0, lwe}, {28'd0, g.we});
        chk({tag, ".wdata"}, lwd, g.wdata);
        chk({tag, ".addr"}, ladr, g.addr);
        @(negedge clk);
        chk({tag, ".pulse_end"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, ".rdata_idle"}, rsp_rdata_o, 32'd0);
        chk({tag, ".err_idle"}, {31'd0, rsp_err_o}, 32'd0);
    endtask

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    initial begin
        int pulses;
        // Reset state
        @(negedge clk);
        chk("rst.ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst.rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst.mem_en", {31'd0, mem_en_o}, 32'd0);
        chk("rst.mem_we", {28'd0, mem_we_o}, 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        preload(6'd4, 32'h8899AABB);
        preload(6'd8, 32'hDEADBEEF);
        preload(6'd9, 32'hAAAAAAAA);
        preload(6'd12, 32'h11223344);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rel.ready", {31'd0, req_ready_o}, 32'd1);

        // Loads
        run("ld_w10",   0, W, 0, 32'h10, 0, 32'h8899AABB, 0, 2, 1, 4'h0, 0);
        run("ld_b11s",  0, B, 0, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 1, 4'h0, 0);
        run("ld_b11u",  0, B, 1, 32'h11, 0, 32'h000000AA, 0, 2, 1, 4'h0, 0);
        run("ld_h12s",  0, H, 0, 32'h12, 0, 32'hFFFF8899, 0, 2, 1, 4'h0, 0);
        run("ld_h10u",  0, H, 1, 32'h10, 0, 32'h0000AABB, 0, 2, 1, 4'h0, 0);
        run("ld_b13s",  0, B, 0, 32'h13, 0, 32'hFFFFFF88, 0, 2, 1, 4'h0, 0);

        // Stores
        run("st_h22",   1, H, 0, 32'h22, 32'h00001234, 0, 0, 3, 2, 4'hF, 32'h1234BEEF);
        run("ld_w20a",  0, W, 0, 32'h20, 0, 32'h1234BEEF, 0, 2, 1, 4'h0, 0);
        run("st_b20",   1, B, 0, 32'h20, 32'hABCDEFCC, 0, 0, 2, 1, 4'h1, 32'hABCDEFCC);
        run("ld_w20b",  0, W, 0, 32'h20, 0, 32'h1234BECC, 0, 2, 1, 4'h0, 0);
        run("st_b21",   1, B, 0, 32'h21, 32'h0000005A, 0, 0, 3, 2, 4'hF, 32'h12345ACC);
        run("ld_w20c",  0, W, 0, 32'h20, 0, 32'h12345ACC, 0, 2, 1, 4'h0, 0);
        run("st_w10",   1, W, 0, 32'h10, 32'hCAFEF00D, 0, 0, 2, 1, 4'hF, 32'hCAFEF00D);
        run("ld_w10b",  0, W, 0, 32'h10, 0, 32'hCAFEF00D, 0, 2, 1, 4'h0, 0);
        run("st_h24",   1, H, 0, 32'h24, 32'h55667788, 0, 0, 2, 1, 4'h3, 32'h55667788);
        run("ld_w24",   0, W, 0, 32'h24, 0, 32'hAAAA7788, 0, 2, 1, 4'h0, 0);

        // Errors: no memory access, 1-cycle latency
        run("err_w13",  0, W, 0, 32'h13, 0, 0, 1, 1, 0, 4'h0, 0);
        run("err_h01",  0, H, 0, 32'h01, 0, 0, 1, 1, 0, 4'h0, 0);
        run("err_sz3",  0, X, 0, 32'h00, 0, 0, 1, 1, 0, 4'h0, 0);
        run("err_stw",  1, W, 0, 32'h22, 32'hFFFFFFFF, 0, 1, 1, 0, 4'h0, 0);
        run("ld_w20d",  0, W, 0, 32'h20, 0, 32'h12345ACC, 0, 2, 1, 4'h0, 0);

        // Reset during RMW_WR
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = B; req_unsigned_i = 1'b0;
        req_addr_i = 32'h31; req_wdata_i = 32'h00000099;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("rmwrst.rd_en", {31'd0, mem_en_o}, 32'd1);
        chk("rmwrst.rd_we", {28'd0, mem_we_o}, 32'd0);
        @(negedge clk);
        chk("rmwrst.wr_we", {28'd0, mem_we_o}, 32'hF);
        chk("rmwrst.wr_data", mem_wdata_o, 32'h11229944);
        #1 rst_i = 1'b1;
        #1;
        chk("rmwrst.en_drop", {31'd0, mem_en_o}, 32'd0);
        chk("rmwrst.we_drop", {28'd0, mem_we_o}, 32'd0);
        chk("rmwrst.ready", {31'd0, req_ready_o}, 32'd0);
        pulses = 0;
        @(negedge clk);
        if (rsp_valid_o) pulses++;
        rst_i = 1'b0;
        @(negedge clk);
        if (rsp_valid_o) pulses++;
        chk("rmwrst.ready_rel", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        if (rsp_valid_o) pulses++;
        chk("rmwrst.no_rsp", pulses, 0);
        chk("rmwrst.ram", ram[12], 32'h11223344);
        run("ld_w30",   0, W, 0, 32'h30, 0, 32'h11223344, 0, 2, 1, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_port_b.md
# lsu_port_b

Load/store unit between the core's memory stage and the read/write port (port B) of the dual-port data RAM. Accepts one byte, halfword or word load/store at a time and checks alignment. Sign- or zero-extends load data. Because the RAM only supports lane-0 partial writes (byte enables 0001 and 0011) besides full-word writes (1111), any partial store to another lane is done as a read-modify-write.

## Interface
- `MISALIGN_ERR`, default 1: 1 = misaligned requests return an error with no memory access; 0 = the low address bits are forced to the natural alignment and the request proceeds.
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`
- `req_we_i`  in  1  1 = store, 0 = load
- `req_size_i`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- `req_unsigned_i`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr_i`  in  32  byte address
- `req_wdata_i`  in  32  store data, LSB-aligned
- `rsp_valid_o`  out  1  one-cycle response pulse
- `rsp_rdata_o`  out  32  extended load data; 0 for stores and errors
- `rsp_err_o`  out  1  misaligned or illegal-size request; valid with `rsp_valid_o`
- `mem_addr_o`  out  32  word-aligned byte address {addr[31:2], 2'b00}
- `mem_en_o`  out  1  port-B enable
- `mem_we_o`  out  4  byte-write mask: only 0000, 0001, 0011 or 1111 are ever driven
- `mem_wdata_o`  out  32  write data
- `mem_rdata_i`  in  32  read data; combinational, same cycle as address

## Operation
- One request outstanding; no queuing. The request is latched into registers on acceptance.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- `req_ready_o` = 1 only in IDLE.
- **Error check:** an error is raised for any of the following; the FSM then goes IDLE -> RESP with `rsp_err_o` = 1.
  - size 11, regardless of the parameter.
  - With `MISALIGN_ERR` = 1: half with addr[0] = 1, or word with addr[1:0] != 0.
- **Load:** IDLE -> LOAD -> RESP.
  - LOAD drives `mem_en_o` = 1, `mem_we_o` = 0000.
  - Byte lane addr[1:0] or half lane addr[1] is extracted from `mem_rdata_i` and extended into the result register.
- **Store, word or lane-0 partial** (byte at addr[1:0] = 00, half at addr[1] = 0): IDLE -> STORE -> RESP.
  - STORE drives `mem_en_o` = 1.
  - `mem_we_o` = 1111, 0001 or 0011 respectively.
  - `mem_wdata_o` = `req_wdata_i` as latched.
- **Store, other lanes:** IDLE -> RMW_RD -> RMW_WR -> RESP.
  - RMW_RD reads the word (`mem_we_o` = 0000) and registers it.
  - RMW_WR writes the merged word (new byte/half in its lane, other bytes unchanged) with `mem_we_o` = 1111.
- **RESP:** `rsp_valid_o` = 1 for exactly one cycle, then IDLE.
- `mem_*` outputs decode combinationally from state and latched request. In IDLE and RESP they are all 0.

## Timing
- Reset: state IDLE, latched registers 0.
  - All outputs 0 while `rst_i` is high; `req_ready_o` goes to 1 on the first cycle after release.
  - The effect is immediate and asynchronous, so a reset asserted in STORE or RMW_WR drops `mem_en_o`/`mem_we_o` in the same cycle. A partially completed RMW leaves the RAM word in its pre-RMW value.
- Latency from the accept edge to the `rsp_valid_o` cycle:
  - error: 1 cycle
  - load, word/lane-0 store: 2 cycles
  - RMW store: 3 cycles
- RAM write commits on the rising edge that ends STORE or RMW_WR. A load accepted in the cycle `rsp_valid_o` is high cannot occur, because ready is low in RESP. Back-to-back throughput is therefore one request per 3 cycles (4 for RMW).
- Changes on `req_*` after acceptance have no effect.
- `rsp_rdata_o` and `rsp_err_o` are held at 0 outside RESP.

## Test plan
- Load word 0x0000_0010 with RAM[4] = 0x8899AABB -> `mem_en_o` high 1 cycle at addr 0x10 with we 0000, then `rsp_rdata_o` = 0x8899AABB, err 0, 2 cycles after accept.
- Byte loads from addr 0x11 of 0x8899AABB: signed -> 0xFFFFFFAA; unsigned -> 0x000000AA. Half load signed from 0x12 -> 0xFFFF8899.
- Store byte 0xCC to 0x20 -> single STORE cycle with we 0001; subsequent word load -> low byte 0xCC, other bytes unchanged.
- Store half 0x1234 to 0x22 over RAM[8] = 0xDEADBEEF -> RMW_RD then RMW_WR with we 1111, wdata 0x1234BEEF; response 3 cycles after accept.
- Word load at 0x13, half at 0x01, size 11 -> `rsp_err_o` = 1, `rsp_valid_o` 1 cycle after accept, `mem_en_o` never asserted.
- Assert `rst_i` during RMW_WR -> `mem_en_o`/`mem_we_o` 0 in the same cycle, RAM word unchanged, `rsp_valid_o` never pulses, `req_ready_o` = 1 one cycle after release.
